ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
- Shares one 256x8 dual-address RAM (sync write, combinational read) among NREQ requesters.
- Round-robin arbitration issues at most one access (read or write) per cycle.
- Drives the RAM write enable, write/read addresses and write data; registers read data back to the granted requester.
- Sits between client blocks and the RAM instance; the RAM itself stays a separate instance.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 8, data width in bits
DEPTH, 8, address width in bits (RAM holds 2**DEPTH words)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req  input  NREQ  per-requester access request, level
wr  input  NREQ  per-requester op type (1 write, 0 read), valid with req
addr  input  NREQ*DEPTH  flattened per-requester address, slice i = [i*DEPTH +: DEPTH]
wdata  input  NREQ*WIDTH  flattened per-requester write data
gnt  output  NREQ  one-hot grant pulse, one cycle
rvalid  output  NREQ  one-hot read-data-valid pulse, one cycle
rdata  output  WIDTH  read data, valid when any rvalid bit is high
ram_w_sig  output  1  RAM write enable
ram_add_w  output  DEPTH  RAM write address
ram_add_r  output  DEPTH  RAM read address
ram_din  output  WIDTH  RAM write data
ram_dout  input  WIDTH  RAM combinational read data

Behaviour:
- Reset (async on rst_n low): gnt, rvalid, rdata, ram_w_sig, ram_add_w, ram_add_r, ram_din, priority pointer and command registers all 0.
- Reset during an in-flight write forces ram_w_sig low immediately, so no write occurs. Pending grants and read returns are dropped.
- Arbitration cycle t:
  - Eligible set = req & ~gnt. A requester is not eligible in the cycle its gnt is high.
  - Winner = first eligible index at or above the pointer, wrapping from NREQ-1 to 0.
  - At the posedge ending t: gnt <= onehot(winner); command regs capture wr, addr and wdata of the winner; pointer <= (winner+1) mod NREQ.
  - No eligible requester: gnt <= 0, pointer unchanged, ram_w_sig <= 0.
- Issue cycle t+1:
  - Write: ram_w_sig=1, ram_add_w=addr, ram_din=wdata. The RAM commits at the posedge ending t+1.
  - Read: ram_add_r=addr, ram_w_sig=0. rdata <= ram_dout at the posedge ending t+1.
- Return cycle t+2 (reads only): rvalid[winner]=1, rdata holds the read value until the next read return.
- Latencies: gnt is 1 cycle after req is sampled; write commit is at the end of the gnt cycle; rvalid is 2 cycles after req.
- Requester contract:
  - Hold req, wr, addr and wdata stable until gnt is seen.
  - req still high in the cycle after gnt counts as a new request.
- Throughput: one op per cycle across requesters. A single requester gets at most one grant per 2 cycles.
- Ordering and hazards:
  - A write granted in cycle t+1 is visible to any read issued in t+2 or later.
  - Same-cycle read/write conflicts cannot occur (single issue).
- ram_add_r and ram_add_w hold their last values when idle.

Optional Feature:
RAM_ARB_WPROT_EN
- With the macro: adds input wprot_base (DEPTH) and output wprot_err (NREQ).
- A granted write with addr >= wprot_base is still granted, but ram_w_sig stays 0 in the issue cycle.
- The same cycle, wprot_err[winner] pulses for one cycle. wprot_err resets to 0. Reads are unaffected.
- Without the macro: the ports are absent and all writes commit.

Decomposition:
- Package ram_arb_pkg: default constants for NREQ, WIDTH and DEPTH; op encoding constants OP_RD=0, OP_WR=1; a function converting an index to one-hot.
- One sub-module, rr_pick: combinational round-robin picker. Inputs are the eligible vector and the pointer; outputs are the one-hot winner, its index, and an any-valid flag.

Test Plan:
- Reset release, no req -> gnt=0, rvalid=0, ram_w_sig=0 for 10 cycles; all RAM address outputs 0.
- req[1] write addr=8'h3C, wdata=8'hA5 -> gnt[1] next cycle with ram_w_sig=1, ram_add_w=3C, ram_din=A5. Then req[2] read 3C -> rvalid[2] two cycles after req, rdata=A5.
- req=4'b1111 held, all reads -> grants in order 0,1,2,3,0,... with one grant every cycle and no requester granted in consecutive cycles.
- Write to 8'h10 by req[0] followed immediately by a read of 8'h10 by req[3] -> read returns the new data.
- rst_n pulled low in the issue cycle of a write to 8'h20 -> ram_w_sig drops at once and a later read of 20 returns the old value. All outputs 0 during reset.
- With RAM_ARB_WPROT_EN, wprot_base=8'hF0:
  - write to F5 -> gnt pulses, ram_w_sig=0, wprot_err pulses.
  - write to EF -> commits normally.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared constants, op encoding and one-hot helper for the RAM arbiter slice.
package ram_arb_pkg;

  localparam int unsigned NREQ_DEF  = 4;
  localparam int unsigned WIDTH_DEF = 8;
  localparam int unsigned DEPTH_DEF = 8;
  localparam int unsigned NREQ_MAX  = 8;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_e;

  function automatic logic [NREQ_MAX-1:0] idx_to_onehot(input logic [2:0] idx);
    return NREQ_MAX'(1) << idx;
  endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester-side bus of the RAM arbiter: per-client request/command in, grant and read return out.
interface ram_arbiter_if #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
);

  logic [NREQ-1:0]       req;
  logic [NREQ-1:0]       wr;
  logic [NREQ*DEPTH-1:0] addr;
  logic [NREQ*WIDTH-1:0] wdata;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       rvalid;
  logic [WIDTH-1:0]      rdata;

  modport master (
    output req, wr, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, wr, addr, wdata,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first eligible index at or above the pointer, wrapping.
module rr_pick
  import ram_arb_pkg::*;
#(
  parameter  int unsigned NREQ = NREQ_DEF,
  localparam int unsigned PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_elig,
  input  logic [PW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_onehot_c,
  output logic [PW-1:0]   o_idx_c,
  output logic            o_any_c
);

  logic [PW-1:0] w_idx;
  logic          w_any;

  // Scan from the farthest offset down so the closest eligible index wins.
  always_comb begin
    w_idx = '0;
    w_any = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (i_elig[PW'((int'(i_ptr) + k) % NREQ)]) begin
        w_idx = PW'((int'(i_ptr) + k) % NREQ);
        w_any = 1'b1;
      end
    end
  end

  assign o_idx_c    = w_idx;
  assign o_any_c    = w_any;
  assign o_onehot_c = w_any ? NREQ'(idx_to_onehot(3'(w_idx))) : '0;

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one sync-write / comb-read RAM among NREQ requesters.
// Optional write-protect window above wprot_base is built with RAM_ARB_WPROT_EN.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter  int unsigned NREQ  = NREQ_DEF,
  parameter  int unsigned WIDTH = WIDTH_DEF,
  parameter  int unsigned DEPTH = DEPTH_DEF,
  localparam int unsigned PW    = $clog2(NREQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  ram_arbiter_if.slave     bus,
  output logic             ram_w_sig,
  output logic [DEPTH-1:0] ram_add_w,
  output logic [DEPTH-1:0] ram_add_r,
  output logic [WIDTH-1:0] ram_din,
  input  logic [WIDTH-1:0] ram_dout
`ifdef RAM_ARB_WPROT_EN
  ,
  input  logic [DEPTH-1:0] wprot_base,
  output logic [NREQ-1:0]  wprot_err
`endif
);

  logic [NREQ-1:0]  r_gnt;
  logic [NREQ-1:0]  r_rvalid;
  logic [WIDTH-1:0] r_rdata;
  logic [PW-1:0]    r_ptr;
  op_e              r_cmd_op;
  logic             r_w_sig;
  logic [DEPTH-1:0] r_add_w;
  logic [DEPTH-1:0] r_add_r;
  logic [WIDTH-1:0] r_din;

  logic [NREQ-1:0]  w_elig;
  logic [NREQ-1:0]  w_win_oh;
  logic [PW-1:0]    w_win_idx;
  logic [PW-1:0]    w_ptr_nxt;
  logic             w_any;
  logic             w_win_wr;
  logic [DEPTH-1:0] w_win_addr;
  logic [WIDTH-1:0] w_win_wdata;
  logic             w_wr_ok;

  // A requester holding req through its grant cycle is not re-granted back to back.
  assign w_elig = bus.req & ~r_gnt;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .i_elig     (w_elig),
    .i_ptr      (r_ptr),
    .o_onehot_c (w_win_oh),
    .o_idx_c    (w_win_idx),
    .o_any_c    (w_any)
  );

  always_comb begin
    w_win_wr    = 1'b0;
    w_win_addr  = '0;
    w_win_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_win_oh[i]) begin
        w_win_wr    = bus.wr[i];
        w_win_addr  = bus.addr[i*DEPTH +: DEPTH];
        w_win_wdata = bus.wdata[i*WIDTH +: WIDTH];
      end
    end
  end

  assign w_ptr_nxt = (w_win_idx == PW'(NREQ - 1)) ? '0 : w_win_idx + PW'(1);

`ifdef RAM_ARB_WPROT_EN
  logic            w_prot;
  logic [NREQ-1:0] r_wprot_err;

  // Protected writes keep their grant but never raise the RAM write enable.
  assign w_prot  = w_win_wr && (w_win_addr >= wprot_base);
  assign w_wr_ok = w_any && w_win_wr && !w_prot;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_wprot_err <= '0;
    else        r_wprot_err <= w_prot ? w_win_oh : '0;
  end

  assign wprot_err = r_wprot_err;
`else
  assign w_wr_ok = w_any && w_win_wr;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gnt    <= '0;
      r_rvalid <= '0;
      r_rdata  <= '0;
      r_ptr    <= '0;
      r_cmd_op <= OP_RD;
      r_w_sig  <= 1'b0;
      r_add_w  <= '0;
      r_add_r  <= '0;
      r_din    <= '0;
    end else begin
      r_gnt   <= w_win_oh;
      r_w_sig <= w_wr_ok;
      if (w_any) begin
        r_ptr    <= w_ptr_nxt;
        r_cmd_op <= op_e'(w_win_wr);
        if (w_win_wr) begin
          r_add_w <= w_win_addr;
          r_din   <= w_win_wdata;
        end else begin
          r_add_r <= w_win_addr;
        end
      end
      // Read return: capture RAM data at the end of the issue cycle.
      r_rvalid <= (r_cmd_op == OP_RD) ? r_gnt : '0;
      if ((|r_gnt) && (r_cmd_op == OP_RD)) r_rdata <= ram_dout;
    end
  end

  assign bus.gnt    = r_gnt;
  assign bus.rvalid = r_rvalid;
  assign bus.rdata  = r_rdata;
  assign ram_w_sig  = r_w_sig;
  assign ram_add_w  = r_add_w;
  assign ram_add_r  = r_add_r;
  assign ram_din    = r_din;

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: behavioural arbiter/memory model feeds expectation queues.
// Exercises write protection when built with RAM_ARB_WPROT_EN.
module tb_ram_arbiter;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 8;
  localparam int          NR    = NREQ;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  ram_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  logic       ram_w_sig;
  logic [7:0] ram_add_w, ram_add_r, ram_din, ram_dout;
`ifdef RAM_ARB_WPROT_EN
  logic [7:0]      wprot_base;
  logic [NREQ-1:0] wprot_err;
`endif

  ram_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .DEPTH(DEPTH)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .ram_w_sig (ram_w_sig),
    .ram_add_w (ram_add_w),
    .ram_add_r (ram_add_r),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout)
`ifdef RAM_ARB_WPROT_EN
    ,
    .wprot_base(wprot_base),
    .wprot_err (wprot_err)
`endif
  );

  // Environment RAM: sync write, combinational read.
  logic [7:0] ram [256] = '{default: 8'h00};
  always @(posedge clk) if (ram_w_sig) ram[ram_add_w] <= ram_din;
  assign ram_dout = ram[ram_add_r];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int         due;
    int         idx;
    bit         wr;
    logic [7:0] addr;
    logic [7:0] data;
    bit         prot;
  } gexp_t;

  typedef struct {
    int         due;
    int         idx;
    logic [7:0] data;
  } rexp_t;

  gexp_t      q_g[$];
  rexp_t      q_r[$];
  logic [7:0] ref_mem [256] = '{default: 8'h00};
  int         m_ptr  = 0;
  int         m_last = -1;
  bit         pw_v   = 1'b0;
  logic [7:0] pw_a, pw_d;

  // Reference model: decides each cycle's winner from the sampled requests.
  always @(negedge clk) begin : model
    int    win;
    gexp_t e;
    rexp_t r;
    if (!rst_n) begin
      q_g.delete();
      q_r.delete();
      m_ptr  = 0;
      m_last = -1;
      pw_v   = 1'b0;
    end else begin
      if (pw_v) ref_mem[pw_a] = pw_d;
      pw_v = 1'b0;
      win  = -1;
      for (int k = 0; k < NR; k++)
        if (win < 0 && bus.req[(m_ptr + k) % NR] && ((m_ptr + k) % NR) != m_last)
          win = (m_ptr + k) % NR;
      m_last = win;
      if (win >= 0) begin
        e.due  = cyc + 1;
        e.idx  = win;
        e.wr   = bus.wr[win];
        e.addr = bus.addr[win*8 +: 8];
        e.data = bus.wdata[win*8 +: 8];
        e.prot = 1'b0;
`ifdef RAM_ARB_WPROT_EN
        e.prot = e.wr && (e.addr >= wprot_base);
`endif
        if (e.wr && !e.prot) begin
          pw_v = 1'b1;
          pw_a = e.addr;
          pw_d = e.data;
        end
        if (!e.wr) begin
          r.due  = cyc + 2;
          r.idx  = win;
          r.data = ref_mem[e.addr];
          q_r.push_back(r);
        end
        q_g.push_back(e);
        m_ptr = (win + 1) % NR;
      end
    end
  end

  always @(negedge clk) begin : monitor
    gexp_t           e;
    rexp_t           r;
    logic [NREQ-1:0] eg, er;
    bit              have_g, have_r, ew;
`ifdef RAM_ARB_WPROT_EN
    logic [NREQ-1:0] ee;
`endif
    if (!rst_n) begin
      chk("rst_gnt",    32'(bus.gnt),    32'd0);
      chk("rst_rvalid", 32'(bus.rvalid), 32'd0);
      chk("rst_rdata",  32'(bus.rdata),  32'd0);
      chk("rst_w_sig",  32'(ram_w_sig),  32'd0);
      chk("rst_add_w",  32'(ram_add_w),  32'd0);
      chk("rst_add_r",  32'(ram_add_r),  32'd0);
      chk("rst_din",    32'(ram_din),    32'd0);
    end else begin
      eg = '0; er = '0; have_g = 1'b0; have_r = 1'b0; ew = 1'b0;
`ifdef RAM_ARB_WPROT_EN
      ee = '0;
`endif
      if (q_g.size() > 0 && q_g[0].due == cyc) begin
        e          = q_g.pop_front();
        have_g     = 1'b1;
        eg[e.idx]  = 1'b1;
        ew         = e.wr && !e.prot;
`ifdef RAM_ARB_WPROT_EN
        if (e.prot) ee[e.idx] = 1'b1;
`endif
      end
      chk("gnt",       32'(bus.gnt),   32'(eg));
      chk("ram_w_sig", 32'(ram_w_sig), 32'(ew));
      if (have_g && ew) begin
        chk("ram_add_w", 32'(ram_add_w), 32'(e.addr));
        chk("ram_din",   32'(ram_din),   32'(e.data));
      end
      if (have_g && !e.wr) chk("ram_add_r", 32'(ram_add_r), 32'(e.addr));
`ifdef RAM_ARB_WPROT_EN
      chk("wprot_err", 32'(wprot_err), 32'(ee));
`endif
      if (q_r.size() > 0 && q_r[0].due == cyc) begin
        r         = q_r.pop_front();
        have_r    = 1'b1;
        er[r.idx] = 1'b1;
      end
      chk("rvalid", 32'(bus.rvalid), 32'(er));
      if (have_r) chk("rdata", 32'(bus.rdata), 32'(r.data));
    end
  end

  task automatic set_cmd(input int i, input bit w, input logic [7:0] a, input logic [7:0] d);
    bus.req[i]         = 1'b1;
    bus.wr[i]          = w;
    bus.addr[i*8 +: 8]  = a;
    bus.wdata[i*8 +: 8] = d;
  endtask

  // Raise one request and hold it until granted; called just after a posedge.
  task automatic issue(input int i, input bit w, input logic [7:0] a, input logic [7:0] d);
    set_cmd(i, w, a, d);
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      if (bus.gnt[i]) begin
        bus.req[i] = 1'b0;
        return;
      end
    end
    n_chk++;
    n_err++;
    $display("FAIL gnt_timeout: requester %0d got no grant within 20 cycles", i);
    bus.req[i] = 1'b0;
  endtask

  initial begin
    bus.req   = '0;
    bus.wr    = '0;
    bus.addr  = '0;
    bus.wdata = '0;
`ifdef RAM_ARB_WPROT_EN
    wprot_base = 8'hF0;
`endif
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Idle after reset: monitor sees no grants or writes.
    repeat (10) @(posedge clk);
    #1;
    chk("idle_add_w", 32'(ram_add_w),   32'd0);
    chk("idle_add_r", 32'(ram_add_r),   32'd0);
    chk("idle_din",   32'(ram_din),     32'd0);
    chk("idle_rdata", 32'(bus.rdata),   32'd0);

    issue(1, 1'b1, 8'h3C, 8'hA5);
    issue(2, 1'b0, 8'h3C, 8'h00);
    repeat (3) @(posedge clk);
    #1 chk("rd_3c", 32'(bus.rdata), 32'h0A5);

    // All four requesters reading continuously.
    for (int i = 0; i < NR; i++) set_cmd(i, 1'b0, 8'(8'h3C + i), 8'h00);
    repeat (12) @(posedge clk);
    #1 bus.req = '0;
    repeat (3) @(posedge clk);
    #1;

    // Write immediately followed by a read of the same address.
    issue(0, 1'b1, 8'h10, 8'h5A);
    issue(3, 1'b0, 8'h10, 8'h00);
    repeat (3) @(posedge clk);
    #1 chk("raw_10", 32'(bus.rdata), 32'h05A);

    // Reset in the issue cycle of a write must suppress it.
    issue(0, 1'b1, 8'h20, 8'h11);
    set_cmd(1, 1'b1, 8'h20, 8'h99);
    for (int n = 0; n < 20 && !bus.gnt[1]; n++) begin
      @(posedge clk); #1;
    end
    chk("rst_wr_gnt_seen", 32'(bus.gnt[1]), 32'd1);
    rst_n = 1'b0;
    bus.req[1] = 1'b0;
    #1;
    chk("rst_drop_w_sig", 32'(ram_w_sig), 32'd0);
    chk("rst_drop_gnt",   32'(bus.gnt),   32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    issue(2, 1'b0, 8'h20, 8'h00);
    repeat (3) @(posedge clk);
    #1 chk("rd_20_old", 32'(bus.rdata), 32'h011);

`ifdef RAM_ARB_WPROT_EN
    issue(0, 1'b1, 8'hF5, 8'h77);
    issue(1, 1'b0, 8'hF5, 8'h00);
    repeat (3) @(posedge clk);
    #1 chk("prot_f5", 32'(bus.rdata), 32'h000);
    issue(2, 1'b1, 8'hEF, 8'h66);
    issue(3, 1'b0, 8'hEF, 8'h00);
    repeat (3) @(posedge clk);
    #1 chk("prot_ef", 32'(bus.rdata), 32'h066);
`endif

    // Random traffic on a small address window to provoke hazards.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (bus.gnt[i] || !bus.req[i]) begin
          if ($urandom_range(0, 1) == 1) begin
            logic [7:0] a;
            a = 8'($urandom_range(0, 15));
`ifdef RAM_ARB_WPROT_EN
            if ($urandom_range(0, 7) == 0) a = 8'($urandom_range(8'hE8, 8'hFF));
`endif
            set_cmd(i, 1'($urandom_range(0, 1)), a, 8'($urandom));
          end else begin
            bus.req[i] = 1'b0;
          end
        end
      end
      @(posedge clk); #1;
    end
    bus.req = '0;
    repeat (5) @(posedge clk);
    #1 chk("q_drain", 32'(q_g.size() + q_r.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
